// File: rtl/quant_pkg.sv
// -----------------------------------------------------------------------------
// quant_pkg
//  Shared types and constants for the fp32 <-> int8 quant/dequant blocks.
//  Contents:
//   fp32_t       IEEE-754 binary32 field view
//   fp_class_e   coarse operand class (zero/normal/inf/nan)
//   fp32_class   special-case decode; denormals classify as zero (flushed)
//   q_s1_t       multiply-stage register contents
//   q_s2_t       align-stage register contents
// -----------------------------------------------------------------------------
package quant_pkg;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] mant;
   } fp32_t;

   localparam int FP32_BIAS     = 127;
   localparam int INT8_MAX      = 127;
   localparam int INT8_MIN_SYM  = -127;
   localparam int INT8_MIN_ASYM = -128;

   typedef enum logic [1:0] {
      FP_ZERO,
      FP_NORM,
      FP_INF,
      FP_NAN
   } fp_class_e;

   // Denormals have no hidden bit in this datapath, so they are treated as zero.
   function automatic fp_class_e fp32_class(input fp32_t f);
      fp_class_e c;
      if (f.exp == 8'd0)
         c = FP_ZERO;
      else if (f.exp == 8'hFF)
         c = (f.mant != 23'd0) ? FP_NAN : FP_INF;
      else
         c = FP_NORM;
      return c;
   endfunction

   // exp holds e_a + e_b - bias as a 10-bit two's-complement value.
   typedef struct packed {
      logic        sign;
      logic [9:0]  exp;
      logic [47:0] prod;
      logic        nan;
      logic        inf;
      logic        zero;
   } q_s1_t;

   typedef struct packed {
      logic        sign;
      logic [8:0]  mag;
      logic        guard;
      logic        sticky;
      logic        fsat;
      logic        nan;
      logic        inf;
      logic        zero;
   } q_s2_t;

endpackage

// File: rtl/quant_round_sat.sv
// -----------------------------------------------------------------------------
// quant_round_sat
//  Combinational round/saturate: round-to-nearest-even on (mag lsb, guard,
//  sticky), apply sign, clamp to the int8 range, flag clamping.
//  Ports:
//   sign       in   result sign
//   mag        in   9-bit integer magnitude (pre-round)
//   guard      in   first bit below the integer point
//   sticky     in   OR of all bits below guard
//   force_sat  in   magnitude already known to be out of range
//   nan/inf/zero in special-case flags (nan has priority)
//   q          out  two's-complement int8 result
//   sat        out  result was clamped (includes Inf)
// -----------------------------------------------------------------------------
module quant_round_sat
   import quant_pkg::*;
#(
   parameter bit SYMMETRIC = 1'b1
) (
   input  logic       sign,
   input  logic [8:0] mag,
   input  logic       guard,
   input  logic       sticky,
   input  logic       force_sat,
   input  logic       nan,
   input  logic       inf,
   input  logic       zero,
   output logic [7:0] q,
   output logic       sat
);

   localparam logic [7:0] QMAX    = 8'(INT8_MAX);
   localparam logic [7:0] QMIN    = SYMMETRIC ? 8'(INT8_MIN_SYM) : 8'(INT8_MIN_ASYM);
   localparam logic [9:0] NEG_LIM = SYMMETRIC ? 10'd127 : 10'd128;

   logic [9:0] rnd;

   always_comb begin
      rnd = {1'b0, mag} + 10'(guard & (sticky | mag[0]));
      q   = 8'd0;
      sat = 1'b0;
      if (nan) begin
         q   = 8'd0;
      end else if (inf || force_sat) begin
         sat = 1'b1;
         q   = sign ? QMIN : QMAX;
      end else if (zero) begin
         q   = 8'd0;
      end else if (sign) begin
         if (rnd > NEG_LIM) begin
            sat = 1'b1;
            q   = QMIN;
         end else begin
            // Negating a rounded zero yields 0x00, so -0 never escapes.
            q   = ~rnd[7:0] + 8'd1;
         end
      end else begin
         if (rnd > 10'd127) begin
            sat = 1'b1;
            q   = QMAX;
         end else begin
            q   = rnd[7:0];
         end
      end
   end

endmodule

// File: rtl/quant_fp32_int8.sv
// -----------------------------------------------------------------------------
// quant_fp32_int8
//  3-stage pipelined quantizer: out = sat(round_half_even(in_fp * scale)).
//   S1 unpack + 24x24 mantissa multiply, S2 align to the integer point,
//   S3 round/saturate into the output register.
//  Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     input handshake (in_ready independent of in_valid)
//   in_fp, scale          binary32 operands, captured together on accept
//   out_valid/out_ready   output handshake
//   out_int8, out_sat     result and clamp flag, held while stalled
//   sat_clr               synchronous clear of sat_count (wins over increment)
//   sat_count             saturating count of transferred outputs with out_sat
// -----------------------------------------------------------------------------
module quant_fp32_int8
   import quant_pkg::*;
#(
   parameter bit SYMMETRIC = 1'b1,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_fp,
   input  logic [31:0]      scale,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_int8,
   output logic             out_sat,
   input  logic             sat_clr,
   output logic [CNT_W-1:0] sat_count
);

   logic [3:1] vld_pipe;
   logic       ld1, ld2, ld3;

   // A stage loads when it is empty or its successor takes its contents,
   // so bubbles collapse and a full pipe still streams one per cycle.
   assign ld3       = !vld_pipe[3] || out_ready;
   assign ld2       = !vld_pipe[2] || ld3;
   assign ld1       = !vld_pipe[1] || ld2;
   assign in_ready  = ld1;
   assign out_valid = vld_pipe[3];

   // ---------------- S1: unpack + multiply ----------------
   fp32_t     a, b;
   fp_class_e ca, cb;
   q_s1_t     s1_d, s1_q;

   assign a  = in_fp;
   assign b  = scale;
   assign ca = fp32_class(a);
   assign cb = fp32_class(b);

   always_comb begin
      s1_d      = '0;
      s1_d.sign = a.sign ^ b.sign;
      // Range is -125..381, so 10-bit two's complement never wraps.
      s1_d.exp  = {2'b00, a.exp} + {2'b00, b.exp} - 10'(FP32_BIAS);
      s1_d.prod = 48'({1'b1, a.mant}) * 48'({1'b1, b.mant});
      s1_d.nan  = (ca == FP_NAN) || (cb == FP_NAN) ||
                  (ca == FP_INF && cb == FP_ZERO) || (ca == FP_ZERO && cb == FP_INF);
      s1_d.inf  = !s1_d.nan && (ca == FP_INF || cb == FP_INF);
      s1_d.zero = !s1_d.nan && !s1_d.inf && (ca == FP_ZERO || cb == FP_ZERO);
   end

   // ---------------- S2: align ----------------
   // After normalizing so the leading one sits on bit 47, the value is
   // pn * 2^(en - 127 - 47); the integer point lies sh = 174 - en bits up.
   q_s2_t              s2_d, s2_q;
   logic signed [10:0] en, sh;
   logic [47:0]        pn, below;
   logic [5:0]         shu;

   always_comb begin
      s2_d      = '0;
      s2_d.sign = s1_q.sign;
      s2_d.nan  = s1_q.nan;
      s2_d.inf  = s1_q.inf;
      s2_d.zero = s1_q.zero;
      en    = {s1_q.exp[9], s1_q.exp} + {10'd0, s1_q.prod[47]};
      pn    = s1_q.prod[47] ? s1_q.prod : {s1_q.prod[46:0], 1'b0};
      sh    = 11'sd174 - en;
      shu   = sh[5:0];
      below = '0;
      if (sh <= 11'sd39) begin
         // Integer part >= 256: out of range regardless of rounding.
         s2_d.fsat = 1'b1;
      end else if (sh >= 11'sd49) begin
         // Value below 0.5 but nonzero: rounds to zero.
         s2_d.sticky = 1'b1;
      end else begin
         below       = (48'd1 << (shu - 6'd1)) - 48'd1;
         s2_d.mag    = 9'(pn >> shu);
         s2_d.guard  = pn[shu - 6'd1];
         s2_d.sticky = |(pn & below);
      end
   end

   // ---------------- S3: round / saturate ----------------
   logic [7:0] q_d;
   logic       sat_d;

   quant_round_sat #(.SYMMETRIC(SYMMETRIC)) u_round_sat (
      .sign      (s2_q.sign),
      .mag       (s2_q.mag),
      .guard     (s2_q.guard),
      .sticky    (s2_q.sticky),
      .force_sat (s2_q.fsat),
      .nan       (s2_q.nan),
      .inf       (s2_q.inf),
      .zero      (s2_q.zero),
      .q         (q_d),
      .sat       (sat_d)
   );

   // ---------------- registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         out_int8 <= 8'd0;
         out_sat  <= 1'b0;
      end else begin
         if (ld1) vld_pipe[1] <= in_valid;
         if (ld2) vld_pipe[2] <= vld_pipe[1];
         if (ld3) vld_pipe[3] <= vld_pipe[2];
         if (ld3 && vld_pipe[2]) begin
            out_int8 <= q_d;
            out_sat  <= sat_d;
         end
      end
   end

   // Payload registers need no reset: their valid bits gate everything.
   always_ff @(posedge clk) begin
      if (ld1 && in_valid)    s1_q <= s1_d;
      if (ld2 && vld_pipe[1]) s2_q <= s2_d;
   end

   always_ff @(posedge clk) begin
      if (rst || sat_clr)
         sat_count <= '0;
      else if (out_valid && out_ready && out_sat && !(&sat_count))
         sat_count <= sat_count + 1'b1;
   end

endmodule
